// File: rtl/mem_responder.sv
// ---------------------------------------------------------------------------
// mem_responder
//   Memory-side responder for the multicycle control unit's instruction fetch,
//   load and store accesses. It accepts one 16-bit word request at a time,
//   waits a fixed number of wait states, and then either returns read data or
//   commits write data.
//
// Handshake: the requester raises req with we/addr/wdata stable. A request is
//   taken only when the responder is IDLE; the values are latched on that edge
//   and the port inputs are ignored until the next IDLE cycle. ack is a single
//   cycle pulse that marks completion. A req still high in the cycle after ack
//   is a new request, so a requester with nothing further to do drops req in
//   the ack cycle.
//
// Parameters
//   ADDR_W       word-address bits implemented (depth = 2**ADDR_W words)
//   WAIT_CYCLES  wait states between acceptance and ack (0..15)
//
// Ports
//   CLK    in   rising-edge clock
//   Reset  in   asynchronous, active-high reset
//   req    in   request valid, sampled only in IDLE
//   we     in   1 = write, 0 = read
//   addr   in   16-bit word address
//   wdata  in   16-bit write data
//   rdata  out  read data, registered on entry to ACK, held until next read ack
//   ack    out  one-cycle completion pulse
//   busy   out  high while a request is in flight (WAIT or ACK)
//   err    out  high with ack when addr[15:ADDR_W] is non-zero
// ---------------------------------------------------------------------------
module mem_responder #(
  parameter int ADDR_W      = 10,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        CLK,
  input  logic        Reset,
  input  logic        req,
  input  logic        we,
  input  logic [15:0] addr,
  input  logic [15:0] wdata,
  output logic [15:0] rdata,
  output logic        ack,
  output logic        busy,
  output logic        err
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_ACK  = 2'd2
  } state_t;

  localparam int DEPTH = 2 ** ADDR_W;

  state_t      state_q;
  logic [3:0]  cnt_q;
  logic [15:0] addr_q;
  logic [15:0] wdata_q;
  logic        we_q;
  logic [15:0] rdata_q;
  logic        ack_q;
  logic        busy_q;
  logic        err_q;

  logic [15:0] mem [DEPTH];

  // The request being acted on: in IDLE it is the one being latched this
  // edge (needed when WAIT_CYCLES is 0 and ACK follows IDLE directly),
  // otherwise it is the latched copy.
  logic [15:0] cur_addr;
  logic        cur_we;
  logic        cur_oor;
  logic        enter_ack;
  logic        mem_wr_en;
  logic [15:0] rd_word;

  always_comb begin
    cur_addr  = (state_q == S_IDLE) ? addr : addr_q;
    cur_we    = (state_q == S_IDLE) ? we   : we_q;
    // Any set bit above the implemented range is an error; no aliasing.
    cur_oor   = (cur_addr >> ADDR_W) != 16'h0000;
    rd_word   = mem[cur_addr[ADDR_W-1:0]];
    enter_ack = ((state_q == S_IDLE) && req && (WAIT_CYCLES == 0)) ||
                ((state_q == S_WAIT) && (cnt_q == 4'd0));
    // Commit happens on the edge that ends ACK. An async reset forces
    // state_q to IDLE at once, so a pending write can never land.
    mem_wr_en = (state_q == S_ACK) && we_q && !err_q;
  end

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= 16'h0000;
      wdata_q <= 16'h0000;
      we_q    <= 1'b0;
      rdata_q <= 16'h0000;
      ack_q   <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      ack_q <= 1'b0;
      err_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (req) begin
            addr_q  <= addr;
            we_q    <= we;
            wdata_q <= wdata;
            busy_q  <= 1'b1;
            if (WAIT_CYCLES == 0) begin
              state_q <= S_ACK;
              cnt_q   <= 4'd0;
            end else begin
              state_q <= S_WAIT;
              cnt_q   <= 4'(WAIT_CYCLES - 1);
            end
          end
        end
        S_WAIT: begin
          if (cnt_q == 4'd0) begin
            state_q <= S_ACK;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        S_ACK: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase

      if (enter_ack) begin
        ack_q <= 1'b1;
        err_q <= cur_oor;
        // Writes leave rdata alone; out-of-range reads return zero.
        if (!cur_we) begin
          rdata_q <= cur_oor ? 16'h0000 : rd_word;
        end
      end
    end
  end

  // Word store: deliberately not reset, contents survive Reset.
  always_ff @(posedge CLK) begin
    if (mem_wr_en) begin
      mem[addr_q[ADDR_W-1:0]] <= wdata_q;
    end
  end

  assign rdata = rdata_q;
  assign ack   = ack_q;
  assign busy  = busy_q;
  assign err   = err_q;

endmodule

// File: tb/tb_mem_responder.sv
// ---------------------------------------------------------------------------
// tb_mem_responder
//   Directed bench for mem_responder. Three instances share clock and reset:
//   index 0 with WAIT_CYCLES=2, index 1 with WAIT_CYCLES=0, index 2 with
//   WAIT_CYCLES=3. Inputs are driven on the falling edge, outputs sampled on
//   the falling edge (or #1 after an async reset change).
// ---------------------------------------------------------------------------
module tb_mem_responder;

  logic        clk;
  logic        rst;
  logic [2:0]  req_s;
  logic [2:0]  we_s;
  logic [15:0] addr_s  [3];
  logic [15:0] wdata_s [3];
  logic [15:0] rdata_s [3];
  logic [2:0]  ack_s;
  logic [2:0]  busy_s;
  logic [2:0]  err_s;

  int checks = 0;
  int errors = 0;

  logic [15:0] exp_q [$];

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  mem_responder #(.ADDR_W(10), .WAIT_CYCLES(2)) u_w2 (
    .CLK(clk), .Reset(rst), .req(req_s[0]), .we(we_s[0]), .addr(addr_s[0]),
    .wdata(wdata_s[0]), .rdata(rdata_s[0]), .ack(ack_s[0]), .busy(busy_s[0]),
    .err(err_s[0])
  );

  mem_responder #(.ADDR_W(10), .WAIT_CYCLES(0)) u_w0 (
    .CLK(clk), .Reset(rst), .req(req_s[1]), .we(we_s[1]), .addr(addr_s[1]),
    .wdata(wdata_s[1]), .rdata(rdata_s[1]), .ack(ack_s[1]), .busy(busy_s[1]),
    .err(err_s[1])
  );

  mem_responder #(.ADDR_W(10), .WAIT_CYCLES(3)) u_w3 (
    .CLK(clk), .Reset(rst), .req(req_s[2]), .we(we_s[2]), .addr(addr_s[2]),
    .wdata(wdata_s[2]), .rdata(rdata_s[2]), .ack(ack_s[2]), .busy(busy_s[2]),
    .err(err_s[2])
  );

  // ---------------- checker ----------------
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // ---------------- driver ----------------
  // One complete access on instance d. lat is the expected number of cycles
  // from the accepting edge to the ack cycle. With scramble set, the port
  // inputs are changed to a conflicting write while the request is in flight.
  task automatic access(input int d, input logic w, input logic [15:0] a,
                        input logic [15:0] wd, input int lat, input bit scramble,
                        output logic [15:0] rd, output logic e);
    int  n;
    bit  got;
    @(negedge clk);
    req_s[d]   = 1'b1;
    we_s[d]    = w;
    addr_s[d]  = a;
    wdata_s[d] = wd;
    @(posedge clk);
    #1;
    req_s[d] = 1'b0;
    if (scramble) begin
      addr_s[d]  = 16'h0003;
      we_s[d]    = 1'b1;
      wdata_s[d] = 16'hFFFF;
    end
    n   = 0;
    got = 1'b0;
    while (n < 20 && !got) begin
      @(negedge clk);
      n++;
      if (ack_s[d]) got = 1'b1;
      else chk("busy_in_wait", busy_s[d], 1'b1);
    end
    chk("ack_seen", got, 1'b1);
    chk("latency", n, lat);
    chk("busy_at_ack", busy_s[d], 1'b1);
    rd = rdata_s[d];
    e  = err_s[d];
    @(negedge clk);
    chk("ack_one_cycle", ack_s[d], 1'b0);
    chk("busy_back_idle", busy_s[d], 1'b0);
    we_s[d]    = 1'b0;
    addr_s[d]  = 16'h0000;
    wdata_s[d] = 16'h0000;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [15:0] rd;
    logic        e;
    int          cyc;
    int          last;
    int          k;

    rst   = 1'b1;
    req_s = 3'b000;
    we_s  = 3'b000;
    for (int i = 0; i < 3; i++) begin
      addr_s[i]  = 16'h0000;
      wdata_s[i] = 16'h0000;
    end

    // 1. reset and idle
    #1;
    chk("rst_ack", ack_s[0], 1'b0);
    chk("rst_busy", busy_s[0], 1'b0);
    chk("rst_err", err_s[0], 1'b0);
    chk("rst_rdata", rdata_s[0], 16'h0000);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("idle_ack", ack_s[0], 1'b0);
      chk("idle_busy", busy_s[0], 1'b0);
      chk("idle_rdata", rdata_s[0], 16'h0000);
    end

    // 2. write then read back
    access(0, 1'b1, 16'h0005, 16'h1234, 3, 1'b0, rd, e);
    chk("wr5_err", e, 1'b0);
    chk("wr5_rdata_kept", rd, 16'h0000);
    access(0, 1'b0, 16'h0005, 16'h0000, 3, 1'b0, rd, e);
    chk("rd5_data", rd, 16'h1234);
    chk("rd5_err", e, 1'b0);

    // 3. preload 0..3, then hold req across four reads
    for (int i = 0; i < 4; i++) begin
      access(0, 1'b1, 16'(i), 16'hA000 + 16'(i), 3, 1'b0, rd, e);
      exp_q.push_back(16'hA000 + 16'(i));
    end
    @(negedge clk);
    req_s[0]  = 1'b1;
    we_s[0]   = 1'b0;
    addr_s[0] = 16'h0000;
    cyc  = 0;
    last = 0;
    k    = 0;
    while (k < 4 && cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (ack_s[0]) begin
        if (exp_q.size() > 0) chk("burst_rdata", rdata_s[0], exp_q.pop_front());
        chk("burst_err", err_s[0], 1'b0);
        if (k > 0) chk("burst_spacing", cyc - last, 4);
        last = cyc;
        k++;
        if (k < 4) addr_s[0] = 16'(k);
        else req_s[0] = 1'b0;
      end
    end
    chk("burst_count", k, 4);
    @(negedge clk);
    chk("burst_idle_busy", busy_s[0], 1'b0);
    addr_s[0] = 16'h0000;

    // 4. out-of-range write and read
    access(0, 1'b1, 16'h0400, 16'hDEAD, 3, 1'b0, rd, e);
    chk("oor_wr_err", e, 1'b1);
    chk("oor_wr_rdata_kept", rd, 16'hA003);
    access(0, 1'b0, 16'h0400, 16'h0000, 3, 1'b0, rd, e);
    chk("oor_rd_err", e, 1'b1);
    chk("oor_rd_data", rd, 16'h0000);
    access(0, 1'b0, 16'h0000, 16'h0000, 3, 1'b0, rd, e);
    chk("no_alias_data", rd, 16'hA000);
    chk("no_alias_err", e, 1'b0);

    // 5. reset during the wait of a write
    access(0, 1'b1, 16'h0007, 16'h5555, 3, 1'b0, rd, e);
    @(negedge clk);
    req_s[0]   = 1'b1;
    we_s[0]    = 1'b1;
    addr_s[0]  = 16'h0007;
    wdata_s[0] = 16'hBEEF;
    @(posedge clk);
    #1;
    req_s[0] = 1'b0;
    @(negedge clk);
    chk("mid_busy", busy_s[0], 1'b1);
    chk("mid_rdata", rdata_s[0], 16'hA000);
    rst = 1'b1;
    #1;
    chk("mid_rst_busy", busy_s[0], 1'b0);
    chk("mid_rst_ack", ack_s[0], 1'b0);
    chk("mid_rst_rdata", rdata_s[0], 16'h0000);
    @(negedge clk);
    @(negedge clk);
    rst        = 1'b0;
    we_s[0]    = 1'b0;
    addr_s[0]  = 16'h0000;
    wdata_s[0] = 16'h0000;
    access(0, 1'b0, 16'h0007, 16'h0000, 3, 1'b0, rd, e);
    chk("rst_dropped_write", rd, 16'h5555);

    // 6a. zero wait states
    access(1, 1'b1, 16'h0001, 16'h00A1, 1, 1'b0, rd, e);
    access(1, 1'b0, 16'h0001, 16'h0000, 1, 1'b0, rd, e);
    chk("w0_rdata", rd, 16'h00A1);
    chk("w0_err", e, 1'b0);

    // 6b. inputs changed while in flight have no effect
    access(2, 1'b1, 16'h0002, 16'h0B0B, 4, 1'b0, rd, e);
    access(2, 1'b1, 16'h0003, 16'h3333, 4, 1'b0, rd, e);
    access(2, 1'b0, 16'h0002, 16'h0000, 4, 1'b1, rd, e);
    chk("w3_scrambled_rdata", rd, 16'h0B0B);
    chk("w3_scrambled_err", e, 1'b0);
    access(2, 1'b0, 16'h0003, 16'h0000, 4, 1'b0, rd, e);
    chk("w3_no_stray_write", rd, 16'h3333);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
